// File: rtl/nvm_prog_sequencer.sv
// Wishbone master that programs, verifies and reads the NVM synapse matrix word.
// state | meaning: IDLE accept | WR timed write strobe | GAP strobe-low turnaround | RD read, wait ack | CMP verify/retry | DONE response pulse
module nvm_prog_sequencer #(
  parameter logic [31:0] ADDR      = 32'h3000_000C,
  parameter logic [7:0]  WR_HOLD   = 8'd4,
  parameter logic [9:0]  TIMEOUT   = 10'd1023,
  parameter logic [1:0]  MAX_RETRY = 2'd3,
  parameter bit          VERIFY    = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data,
  output logic [1:0]  rsp_status,
  output logic [1:0]  rsp_retries,
  output logic        busy,
  output logic        mwb_cyc_o,
  output logic        mwb_stb_o,
  output logic        mwb_we_o,
  output logic [3:0]  mwb_sel_o,
  output logic [31:0] mwb_adr_o,
  output logic [31:0] mwb_dat_o,
  input  logic [31:0] mwb_dat_i,
  input  logic        mwb_ack_i
);

  typedef enum logic [2:0] {IDLE, WR, GAP, RD, CMP, DONE} state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_VFAIL = 2'b01;
  localparam logic [1:0] ST_TMO   = 2'b10;

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        we_req_q, we_req_d;
  logic [7:0]  wr_cnt_q, wr_cnt_d;
  logic [9:0]  tmo_q, tmo_d;
  logic [1:0]  retry_q, retry_d;
  logic        gap_wr_q, gap_wr_d;
  logic [15:0] rd_q, rd_d;
  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_status_q, rsp_status_d;
  logic [1:0]  rsp_retries_q, rsp_retries_d;
  logic        unused_dat_hi;

  assign unused_dat_hi = ^mwb_dat_i[31:16];

  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    we_req_d      = we_req_q;
    wr_cnt_d      = wr_cnt_q;
    tmo_d         = tmo_q;
    retry_d       = retry_q;
    gap_wr_d      = gap_wr_q;
    rd_d          = rd_q;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    rsp_retries_d = rsp_retries_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          data_d   = req_data;
          we_req_d = req_we;
          retry_d  = 2'd0;
          tmo_d    = 10'd0;
          wr_cnt_d = 8'd1;
          gap_wr_d = 1'b0;
          state_d  = req_we ? WR : RD;
        end
      end
      WR: begin
        if (wr_cnt_q >= WR_HOLD) begin
          if (VERIFY) begin
            state_d  = GAP;
            gap_wr_d = 1'b0;
          end else begin
            state_d      = DONE;
            rsp_status_d = ST_OK;
          end
        end else begin
          wr_cnt_d = wr_cnt_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_wr_q) begin
          state_d  = WR;
          wr_cnt_d = 8'd1;
        end else begin
          state_d = RD;
          tmo_d   = 10'd0;
        end
      end
      RD: begin
        // Ack only counts while our strobe is actually out on the bus.
        if (mwb_stb_o && mwb_ack_i) begin
          rd_d    = mwb_dat_i[15:0];
          state_d = CMP;
        end else if (tmo_q >= TIMEOUT) begin
          state_d      = DONE;
          rsp_status_d = ST_TMO;
        end else begin
          tmo_d = tmo_q + 10'd1;
        end
      end
      CMP: begin
        if (!we_req_q || rd_q == data_q) begin
          state_d      = DONE;
          rsp_status_d = ST_OK;
        end else if (retry_q < MAX_RETRY) begin
          retry_d  = retry_q + 2'd1;
          gap_wr_d = 1'b1;
          state_d  = GAP;
        end else begin
          state_d      = DONE;
          rsp_status_d = ST_VFAIL;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == DONE) begin
      rsp_retries_d = retry_q;
      rsp_data_d    = (we_req_q && !VERIFY) ? data_q : rd_q;
    end
  end

  // Bus outputs are registered from the next state so they align with it.
  always_comb begin
    stb_d       = (state_d == WR) || (state_d == RD && tmo_d < TIMEOUT);
    we_d        = (state_d == WR);
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= IDLE;
      data_q        <= 16'h0;
      we_req_q      <= 1'b0;
      wr_cnt_q      <= 8'd0;
      tmo_q         <= 10'd0;
      retry_q       <= 2'd0;
      gap_wr_q      <= 1'b0;
      rd_q          <= 16'h0;
      stb_q         <= 1'b0;
      we_q          <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 16'h0;
      rsp_status_q  <= 2'b00;
      rsp_retries_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      data_q        <= data_d;
      we_req_q      <= we_req_d;
      wr_cnt_q      <= wr_cnt_d;
      tmo_q         <= tmo_d;
      retry_q       <= retry_d;
      gap_wr_q      <= gap_wr_d;
      rd_q          <= rd_d;
      stb_q         <= stb_d;
      we_q          <= we_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      rsp_retries_q <= rsp_retries_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign busy        = ~req_ready;
  assign mwb_cyc_o   = stb_q;
  assign mwb_stb_o   = stb_q;
  assign mwb_we_o    = we_q;
  assign mwb_sel_o   = stb_q ? 4'hF : 4'h0;
  assign mwb_adr_o   = ADDR;
  assign mwb_dat_o   = {16'h0, data_q};
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign rsp_retries = rsp_retries_q;

endmodule

// File: tb/tb_nvm_prog_sequencer.sv
// Directed bench for nvm_prog_sequencer: WR_HOLD=4, TIMEOUT=8, MAX_RETRY=3, VERIFY=1.
module tb_nvm_prog_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [15:0] req_data;
  logic        req_ready, rsp_valid, busy;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_status, rsp_retries;
  logic        cyc, stb, we_o, ack;
  logic [3:0]  sel;
  logic [31:0] adr, dat_o, dat_i;

  int checks = 0;
  int passed = 0;

  int          rsp_cyc, n_wr;
  logic [99:0] tr_stb, tr_we;
  logic [15:0] r_data;
  logic [1:0]  r_status, r_retries;
  logic        ready_after, valid_after;
  logic [3:0]  sel_wr;
  logic [31:0] adr_wr, dat_wr;

  nvm_prog_sequencer #(
    .ADDR(32'h3000_000C), .WR_HOLD(8'd4), .TIMEOUT(10'd8), .MAX_RETRY(2'd3), .VERIFY(1'b1)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_retries(rsp_retries),
    .busy(busy), .mwb_cyc_o(cyc), .mwb_stb_o(stb), .mwb_we_o(we_o), .mwb_sel_o(sel),
    .mwb_adr_o(adr), .mwb_dat_o(dat_o), .mwb_dat_i(dat_i), .mwb_ack_i(ack)
  );

  always #5 clk = ~clk;

  // Drives one request and plays the slave; cycle c counts from acceptance cycle A.
  task automatic run(input logic we, input logic [15:0] d, input int k,
                     input logic [15:0] v0, input logic [15:0] v1,
                     input logic [15:0] v2, input logic [15:0] v3, input bit stray);
    logic [15:0] vals [4];
    int idx, rd_run;
    bit prev_wr;
    vals = '{v0, v1, v2, v3};
    idx = 0; rd_run = 0; prev_wr = 0; n_wr = 0; rsp_cyc = -1;
    tr_stb = '0; tr_we = '0;
    ready_after = 1'b0; valid_after = 1'b1;
    req_valid = 1'b1; req_we = we; req_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_data = 16'h0;
    for (int c = 1; c < 100; c++) begin
      ack = 1'b0; dat_i = 32'hDEAD_0000;
      tr_stb[c] = stb; tr_we[c] = we_o;
      if (c == 1) begin sel_wr = sel; adr_wr = adr; dat_wr = dat_o; end
      if (stb && we_o) begin
        if (!prev_wr) n_wr++;
        prev_wr = 1;
        if (stray && c == 2) ack = 1'b1;
      end else prev_wr = 0;
      if (stb && !we_o) begin
        rd_run++;
        if (rd_run == k) begin
          ack = 1'b1; dat_i = {16'hBEEF, vals[idx]};
          if (idx < 3) idx++;
        end
      end else rd_run = 0;
      if (rsp_valid) begin
        rsp_cyc = c; r_data = rsp_data; r_status = rsp_status; r_retries = rsp_retries;
        @(posedge clk); #1;
        ready_after = req_ready; valid_after = rsp_valid;
        break;
      end
      @(posedge clk); #1;
    end
    ack = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) $display("FAIL reset_ready: ready=%b busy=%b want 1/0", req_ready, busy); else passed++;
    checks++; if ({cyc, stb, we_o, sel} !== 7'b0) $display("FAIL reset_bus: cyc/stb/we/sel=%b want 0", {cyc, stb, we_o, sel}); else passed++;
    checks++; if (adr !== 32'h3000_000C || dat_o !== 32'h0) $display("FAIL reset_adr_dat: adr=%h dat=%h want 3000000c/0", adr, dat_o); else passed++;
    checks++; if ({rsp_valid, rsp_data, rsp_status, rsp_retries} !== 21'b0) $display("FAIL reset_rsp: got %h want 0", {rsp_valid, rsp_data, rsp_status, rsp_retries}); else passed++;
  endtask

  task automatic test_prog_verify();
    run(1'b1, 16'hA5C3, 2, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'hA5C3, 1'b0);
    checks++; if (rsp_cyc !== 9) $display("FAIL pv_latency: got %0d want 9", rsp_cyc); else passed++;
    checks++; if (tr_stb[9:1] !== 9'b001101111) $display("FAIL pv_stb_trace: got %b want 001101111", tr_stb[9:1]); else passed++;
    checks++; if (tr_we[9:1] !== 9'b000001111) $display("FAIL pv_we_trace: got %b want 000001111", tr_we[9:1]); else passed++;
    checks++; if ({r_status, r_retries} !== 4'b0000 || r_data !== 16'hA5C3) $display("FAIL pv_rsp: st=%b rt=%0d data=%h want 00/0/a5c3", r_status, r_retries, r_data); else passed++;
    checks++; if (sel_wr !== 4'hF || adr_wr !== 32'h3000_000C || dat_wr !== 32'h0000_A5C3) $display("FAIL pv_bus: sel=%h adr=%h dat=%h want f/3000000c/0000a5c3", sel_wr, adr_wr, dat_wr); else passed++;
    checks++; if (ready_after !== 1'b1 || valid_after !== 1'b0) $display("FAIL pv_after: ready=%b valid=%b want 1/0", ready_after, valid_after); else passed++;
  endtask

  task automatic test_retry_pass();
    run(1'b1, 16'hA5C3, 2, 16'hA5C2, 16'hA5C3, 16'hA5C3, 16'hA5C3, 1'b0);
    checks++; if (rsp_cyc !== 18) $display("FAIL retry_latency: got %0d want 18", rsp_cyc); else passed++;
    checks++; if (tr_stb[18:1] !== 18'b001101111001101111) $display("FAIL retry_stb_trace: got %b want 001101111001101111", tr_stb[18:1]); else passed++;
    checks++; if (n_wr !== 2 || r_status !== 2'b00 || r_retries !== 2'd1) $display("FAIL retry_rsp: bursts=%0d st=%b rt=%0d want 2/00/1", n_wr, r_status, r_retries); else passed++;
  endtask

  task automatic test_retry_exhaust();
    run(1'b1, 16'hFFFF, 2, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    checks++; if (rsp_cyc !== 36) $display("FAIL exh_latency: got %0d want 36", rsp_cyc); else passed++;
    checks++; if (n_wr !== 4) $display("FAIL exh_bursts: got %0d want 4", n_wr); else passed++;
    checks++; if (r_status !== 2'b01 || r_retries !== 2'd3 || r_data !== 16'h0000) $display("FAIL exh_rsp: st=%b rt=%0d data=%h want 01/3/0000", r_status, r_retries, r_data); else passed++;
  endtask

  task automatic test_read_timeout();
    run(1'b0, 16'h0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    checks++; if (rsp_cyc !== 10) $display("FAIL tmo_latency: got %0d want 10", rsp_cyc); else passed++;
    checks++; if (tr_stb[10:1] !== 10'b0011111111 || tr_we[10:1] !== 10'b0) $display("FAIL tmo_trace: stb=%b we=%b want 0011111111/0", tr_stb[10:1], tr_we[10:1]); else passed++;
    checks++; if (r_status !== 2'b10 || r_retries !== 2'd0) $display("FAIL tmo_rsp: st=%b rt=%0d want 10/0", r_status, r_retries); else passed++;
  endtask

  task automatic test_read_only();
    run(1'b0, 16'h0, 3, 16'h1234, 16'h0, 16'h0, 16'h0, 1'b0);
    checks++; if (rsp_cyc !== 5) $display("FAIL rd_latency: got %0d want 5", rsp_cyc); else passed++;
    checks++; if (r_data !== 16'h1234 || r_status !== 2'b00) $display("FAIL rd_rsp: data=%h st=%b want 1234/00", r_data, r_status); else passed++;
  endtask

  task automatic test_stray_acks();
    ack = 1'b1; dat_i = 32'h0000_FFFF;
    @(posedge clk); #1;
    ack = 1'b0;
    checks++; if (req_ready !== 1'b1 || stb !== 1'b0 || rsp_valid !== 1'b0) $display("FAIL stray_idle: ready=%b stb=%b valid=%b want 1/0/0", req_ready, stb, rsp_valid); else passed++;
    run(1'b1, 16'h3C69, 2, 16'h3C69, 16'h3C69, 16'h3C69, 16'h3C69, 1'b1);
    checks++; if (tr_stb[9:1] !== 9'b001101111 || tr_we[9:1] !== 9'b000001111) $display("FAIL stray_wr_trace: stb=%b we=%b want 001101111/000001111", tr_stb[9:1], tr_we[9:1]); else passed++;
    checks++; if (rsp_cyc !== 9 || r_status !== 2'b00 || r_retries !== 2'd0) $display("FAIL stray_rsp: cyc=%0d st=%b rt=%0d want 9/00/0", rsp_cyc, r_status, r_retries); else passed++;
  endtask

  task automatic test_async_reset();
    int seen;
    req_valid = 1'b1; req_we = 1'b0; req_data = 16'h5555;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (stb !== 1'b1 || cyc !== 1'b1) $display("FAIL arst_pre: stb=%b cyc=%b want 1/1", stb, cyc); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++; if (stb !== 1'b0 || cyc !== 1'b0) $display("FAIL arst_drop: stb=%b cyc=%b want 0/0", stb, cyc); else passed++;
    checks++; if (req_ready !== 1'b1) $display("FAIL arst_ready: got %b want 1", req_ready); else passed++;
    #4 rst = 1'b0;
    @(posedge clk); #1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) $display("FAIL arst_no_rsp: saw %0d pulses want 0", seen); else passed++;
    run(1'b0, 16'h0, 1, 16'h7E81, 16'h0, 16'h0, 16'h0, 1'b0);
    checks++; if (rsp_cyc !== 3 || r_data !== 16'h7E81 || r_status !== 2'b00) $display("FAIL arst_after: cyc=%0d data=%h st=%b want 3/7e81/00", rsp_cyc, r_data, r_status); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_data = 16'h0; ack = 1'b0; dat_i = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_prog_verify();
    test_retry_pass();
    test_retry_exhaust();
    test_read_timeout();
    test_read_only();
    test_stray_acks();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
